// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  // Low 'cnt' bits set; saturates to all-ones for cnt >= 32.
  function automatic logic [31:0] keep_mask(input logic [31:0] cnt);
    if (cnt >= 32'd32) return '1;
    return (32'd1 << cnt) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the async FIFO read port and packs PACK_RATIO of them into one
// wide valid/ready word. state | meaning: RUN pop+pack, DRAIN wait landing, EMIT send partial.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int PACK_RATIO = 4,
  localparam int OUT_WIDTH  = DATA_WIDTH * PACK_RATIO
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [PACK_RATIO-1:0] out_keep,
  output logic                  out_last
);

  localparam int          CW   = $clog2(PACK_RATIO + 1);
  localparam logic [CW:0] PR_S = (CW + 1)'(PACK_RATIO);

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  inflight_q;
  logic [OUT_WIDTH-1:0]  asm_q, asm_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic [PACK_RATIO-1:0] out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;

  logic                  out_free;
  logic [CW:0]           pend_sum;
  logic                  pop_ok;
  logic [CW-1:0]         cnt_land;
  logic                  word_full;
  logic [PACK_RATIO-1:0] emit_keep;
  logic [OUT_WIDTH-1:0]  emit_data;

  assign out_free = !out_valid_q || out_ready;
  assign pend_sum = {1'b0, count_q} + (CW + 1)'(inflight_q);
  // A pop into a full assembly is allowed only when the landing word leaves the same edge.
  assign pop_ok   = (pend_sum < PR_S) || ((pend_sum == PR_S) && inflight_q && out_free);

  assign fifo_read_en = reset_n && !fifo_empty && (state_q == ST_RUN) && !flush && pop_ok;

  always_comb begin
    emit_keep = PACK_RATIO'(keep_mask(32'(count_q)));
    emit_data = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (emit_keep[i]) emit_data[i*DATA_WIDTH +: DATA_WIDTH] = asm_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    cnt_land     = count_q;
    if (inflight_q) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (count_q == CW'(i)) asm_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      end
      cnt_land = count_q + CW'(1);
    end
    count_d   = cnt_land;
    word_full = (cnt_land == CW'(PACK_RATIO));

    unique case (state_q)
      ST_RUN: begin
        if (word_full && out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = asm_d;
          out_keep_d  = '1;
          out_last_d  = flush_pend_q || flush;
          count_d     = '0;
        end
        if (flush) begin
          state_d      = ST_DRAIN;
          flush_pend_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (inflight_q) begin
          if (word_full && out_free) begin
            out_valid_d  = 1'b1;
            out_data_d   = asm_d;
            out_keep_d   = '1;
            out_last_d   = 1'b1;
            count_d      = '0;
            flush_pend_d = 1'b0;
            state_d      = ST_RUN;
          end
        end else if (count_q != '0) begin
          state_d = ST_EMIT;
        end else begin
          flush_pend_d = 1'b0;
          state_d      = ST_RUN;
        end
      end
      ST_EMIT: begin
        if (out_free) begin
          out_valid_d  = 1'b1;
          out_data_d   = emit_data;
          out_keep_d   = emit_keep;
          out_last_d   = 1'b1;
          count_d      = '0;
          flush_pend_d = 1'b0;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      asm_q        <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      inflight_q   <= fifo_read_en;
      asm_q        <= asm_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model, byte-stream scoreboard, directed and random phases.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int OW = DW * PR;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_read_en;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [PR-1:0] out_keep;
  logic          out_last;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic [PR-1:0] keep;
    logic          last;
    int            cyc;
  } word_t;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [7:0]    src_q[$];
  logic [7:0]    popped_q[$];
  word_t         got_q[$];
  int            cyc = 0;
  int            pops_total = 0;
  bit            expect_nolast = 1'b0;
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic [PR-1:0] prev_keep;
  logic          prev_last;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Accepted word must carry the next n popped bytes in lanes 0..n-1, zeros above.
  task automatic score_word();
    int            n;
    logic [OW-1:0] exp;
    logic [PR-1:0] exp_keep;
    word_t         w;
    n   = 0;
    exp = '0;
    while (n < PR && out_keep[n]) n++;
    exp_keep = PR'((1 << n) - 1);
    check_eq("keep_shape", out_keep, exp_keep);
    check_eq("keep_nonzero", n != 0, 1);
    if (popped_q.size() < n) check_eq("byte_underflow", popped_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (popped_q.size() > 0) exp[i*DW +: DW] = popped_q.pop_front();
    end
    check_eq("word_data", out_data, exp);
    if (n < PR) check_eq("partial_last", out_last, 1);
    if (expect_nolast) check_eq("no_flush_last", out_last, 0);
    w.data = out_data;
    w.keep = out_keep;
    w.last = out_last;
    w.cyc  = cyc;
    got_q.push_back(w);
  endtask

  // FIFO model and output monitor: sample at negedge, update FIFO after the edge.
  initial begin
    bit do_pop;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      do_pop = fifo_read_en && !fifo_empty;
      if (!reset_n) begin
        popped_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_data", out_data, prev_data);
          check_eq("hold_keep", out_keep, prev_keep);
          check_eq("hold_last", out_last, prev_last);
        end
        if (out_valid && out_ready) score_word();
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_keep  = out_keep;
        prev_last  = out_last;
      end
      @(posedge clk);
      #2;
      if (do_pop) begin
        fifo_data = src_q.pop_front();
        popped_q.push_back(fifo_data);
        pops_total++;
      end
      fifo_empty = (src_q.size() == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int target, input int budget);
    int b;
    b = budget;
    while (got_q.size() < target && b > 0) begin
      tick(1);
      b--;
    end
    check_eq(tag, got_q.size(), target);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [OW-1:0] d,
                            input logic [PR-1:0] k, input logic l);
    if (idx >= got_q.size()) begin
      check_eq({tag, "_present"}, got_q.size(), idx + 1);
    end else begin
      check_eq({tag, "_data"}, got_q[idx].data, d);
      check_eq({tag, "_keep"}, got_q[idx].keep, k);
      check_eq({tag, "_last"}, got_q[idx].last, l);
    end
  endtask

  initial begin
    int base;
    int k;
    int pb;
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick(1);

    // Reset with a non-empty FIFO
    for (int i = 0; i < 8; i++) src_q.push_back(8'((i + 1) * 8'h11));
    tick(1);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_rd_en", fifo_read_en, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_keep", out_keep, 0);
      check_eq("rst_last", out_last, 0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Streaming: 8 back-to-back pops, two words four cycles apart
    k = 0;
    @(negedge clk);
    while (!fifo_read_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 8; i++) begin
      check_eq("stream_rd_en", fifo_read_en, 1);
      @(negedge clk);
    end
    check_eq("stream_rd_stop", fifo_read_en, 0);
    tick(1);
    wait_words("stream_words", 2, 30);
    check_word("stream_w0", 0, 32'h44332211, 4'hF, 1'b0);
    check_word("stream_w1", 1, 32'h88776655, 4'hF, 1'b0);
    if (got_q.size() >= 2) check_eq("stream_spacing", got_q[1].cyc - got_q[0].cyc, 4);

    // Backpressure after the first word
    base = got_q.size();
    for (int i = 0; i < 16; i++) src_q.push_back(8'(8'hB0 + i));
    k = 0;
    while (got_q.size() < base + 1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tick(20);
    @(negedge clk);
    check_eq("bp_fifo_left", src_q.size(), 4);
    check_eq("bp_rd_en", fifo_read_en, 0);
    check_eq("bp_valid", out_valid, 1);
    check_eq("bp_held_word", out_data, 32'hB7B6B5B4);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_words("bp_words", base + 4, 40);
    check_word("bp_w0", base, 32'hB3B2B1B0, 4'hF, 1'b0);
    check_word("bp_w1", base + 1, 32'hB7B6B5B4, 4'hF, 1'b0);
    check_word("bp_w2", base + 2, 32'hBBBAB9B8, 4'hF, 1'b0);
    check_word("bp_w3", base + 3, 32'hBFBEBDBC, 4'hF, 1'b0);

    // Partial flush, then pops resume after EMIT
    tick(5);
    base = got_q.size();
    src_q.push_back(8'hA1);
    src_q.push_back(8'hA2);
    src_q.push_back(8'hA3);
    tick(8);
    flush = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hD1 + i));
    @(negedge clk);
    check_eq("flush_cycle_rd", fifo_read_en, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_drain_rd", fifo_read_en, 0);
    @(negedge clk);
    check_eq("flush_emit_rd", fifo_read_en, 0);
    @(negedge clk);
    check_eq("flush_resume_rd", fifo_read_en, 1);
    tick(1);
    wait_words("flush_words", base + 2, 30);
    check_word("flush_part", base, 32'h00A3A2A1, 4'b0111, 1'b1);
    check_word("flush_next", base + 1, 32'hD4D3D2D1, 4'hF, 1'b0);

    // Flush with nothing assembled
    tick(10);
    base = got_q.size();
    pulse_flush();
    tick(10);
    check_eq("idle_flush_words", got_q.size(), base);

    // Flush while the 4th byte is in flight
    base = got_q.size();
    pb   = pops_total;
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hE1 + i));
    k = 0;
    while (pops_total < pb + 3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    pulse_flush();
    tick(10);
    check_eq("inflight_flush_words", got_q.size(), base + 1);
    check_word("inflight_flush", base, 32'hE4E3E2E1, 4'hF, 1'b1);

    // Reset mid-word discards partial lanes
    base = got_q.size();
    src_q.push_back(8'h5A);
    src_q.push_back(8'h5B);
    tick(8);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(8'(i + 1));
    wait_words("rst_mid_words", base + 1, 30);
    tick(5);
    check_eq("rst_mid_count", got_q.size(), base + 1);
    check_word("rst_mid", base, 32'h04030201, 4'hF, 1'b0);

    // Random traffic without flush: every word full, never last
    expect_nolast = 1'b1;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (src_q.size() < 12 && $urandom_range(0, 1) == 1) src_q.push_back(8'($urandom_range(0, 255)));
      tick(1);
    end
    out_ready = 1'b1;
    tick(20);
    expect_nolast = 1'b0;
    pulse_flush();
    tick(10);

    // Random traffic with flushes and backpressure
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      if (src_q.size() < 12 && $urandom_range(0, 1) == 1) src_q.push_back(8'($urandom_range(0, 255)));
      tick(1);
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    tick(30);
    pulse_flush();
    tick(15);
    check_eq("final_fifo_empty", src_q.size(), 0);
    check_eq("final_all_emitted", popped_q.size(), 0);
    check_eq("final_valid_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
